// File: rtl/mult_pair_driver.sv
// Initiator for two multiplier copies: sweeps every operand pair, compares the copies' start-to-done latencies and checks products.
// Optional build macro MULT_DRV_STOP_ON_LEAK_EN ends the sweep at the first latency mismatch.
module mult_pair_driver #(
    parameter int WIDTH      = 4,
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 start,
    output logic [WIDTH-1:0]     multiplierOne,
    output logic [WIDTH-1:0]     multiplicandOne,
    output logic [WIDTH-1:0]     multiplierTwo,
    output logic [WIDTH-1:0]     multiplicandTwo,
    input  logic [2*WIDTH-1:0]   productOne,
    input  logic [2*WIDTH-1:0]   productTwo,
    input  logic                 productDoneOne,
    input  logic                 productDoneTwo,
    output logic                 sweep_done,
    output logic                 leak_seen,
    output logic                 err_seen,
    output logic                 timeout_seen,
    output logic [CNT_W-1:0]     leak_count,
    output logic [2*WIDTH-1:0]   first_leak_idx
);

    localparam int IDX_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CYC_LIM  = CNT_W'(MAX_CYCLES);

`ifdef MULT_DRV_STOP_ON_LEAK_EN
    localparam bit STOP_ON_LEAK = 1'b1;
`else
    localparam bit STOP_ON_LEAK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_one;
    logic [CNT_W-1:0]   lat_two;
    logic               cap_one;
    logic               cap_two;
    logic [IDX_W-1:0]   prod_one;
    logic [IDX_W-1:0]   prod_two;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] umul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return IDX_W'(a) * IDX_W'(b);
    endfunction

    logic               got_one;
    logic               got_two;
    logic               timed_out;
    logic               leak;
    logic               err_one;
    logic               err_two;
    logic               last_pair;
    logic [IDX_W-1:0]   idx_next;

    // A copy counts as done once captured; done seen this cycle also counts.
    assign got_one   = cap_one | productDoneOne;
    assign got_two   = cap_two | productDoneTwo;
    assign timed_out = (cnt == CYC_LIM);
    assign leak      = (lat_one != lat_two);
    assign err_one   = cap_one && (prod_one != umul(multiplierOne, multiplicandOne));
    assign err_two   = cap_two && (prod_two != umul(multiplierTwo, multiplicandTwo));
    assign last_pair = (idx == IDX_LAST);
    assign idx_next  = idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            lat_one         <= '0;
            lat_two         <= '0;
            cap_one         <= 1'b0;
            cap_two         <= 1'b0;
            prod_one        <= '0;
            prod_two        <= '0;
            start           <= 1'b0;
            multiplierOne   <= '0;
            multiplicandOne <= '0;
            multiplierTwo   <= '0;
            multiplicandTwo <= '0;
            sweep_done      <= 1'b0;
            leak_seen       <= 1'b0;
            err_seen        <= 1'b0;
            timeout_seen    <= 1'b0;
            leak_count      <= '0;
            first_leak_idx  <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        idx             <= '0;
                        leak_seen       <= 1'b0;
                        err_seen        <= 1'b0;
                        timeout_seen    <= 1'b0;
                        leak_count      <= '0;
                        first_leak_idx  <= '0;
                        multiplierOne   <= '0;
                        multiplicandOne <= '0;
                        multiplierTwo   <= '1;
                        multiplicandTwo <= '1;
                        start           <= 1'b1;
                        cnt             <= '0;
                        cap_one         <= 1'b0;
                        cap_two         <= 1'b0;
                        state           <= ISSUE;
                    end
                end

                // cnt counts cycles since the start pulse, so the first WAIT cycle reads 1.
                ISSUE: begin
                    cnt   <= cnt + 1'b1;
                    state <= WAIT;
                end

                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (productDoneOne && !cap_one) begin
                        cap_one  <= 1'b1;
                        lat_one  <= cnt;
                        prod_one <= productOne;
                    end
                    if (productDoneTwo && !cap_two) begin
                        cap_two  <= 1'b1;
                        lat_two  <= cnt;
                        prod_two <= productTwo;
                    end
                    if (got_one && got_two) begin
                        state <= CHECK;
                    end else if (timed_out) begin
                        timeout_seen <= 1'b1;
                        if (!got_one) lat_one <= CYC_LIM;
                        if (!got_two) lat_two <= CYC_LIM;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (leak) begin
                        leak_seen  <= 1'b1;
                        leak_count <= sat_inc(leak_count);
                        if (!leak_seen) first_leak_idx <= idx;
                    end
                    if (err_one || err_two) err_seen <= 1'b1;

                    if (last_pair || (STOP_ON_LEAK && leak)) begin
                        sweep_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx             <= idx_next;
                        multiplierOne   <= idx_next[IDX_W-1:WIDTH];
                        multiplicandOne <= idx_next[WIDTH-1:0];
                        multiplierTwo   <= ~idx_next[IDX_W-1:WIDTH];
                        multiplicandTwo <= ~idx_next[WIDTH-1:0];
                        start           <= 1'b1;
                        cnt             <= '0;
                        cap_one         <= 1'b0;
                        cap_two         <= 1'b0;
                        state           <= ISSUE;
                    end
                end

                DONE: begin
                    if (!run) begin
                        sweep_done <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_pair_driver.sv
// Scoreboard bench for mult_pair_driver: mock multiplier copies, expected operands and end-of-sweep flags queued per scenario.
module tb_mult_pair_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         start;
    logic [W-1:0] multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo;
    logic [2*W-1:0] productOne, productTwo;
    logic         productDoneOne, productDoneTwo;
    logic         sweep_done, leak_seen, err_seen, timeout_seen;
    logic [7:0]   leak_count;
    logic [2*W-1:0] first_leak_idx;

    always #5 clk = ~clk;

    mult_pair_driver #(.WIDTH(W), .MAX_CYCLES(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .start(start),
        .multiplierOne(multiplierOne), .multiplicandOne(multiplicandOne),
        .multiplierTwo(multiplierTwo), .multiplicandTwo(multiplicandTwo),
        .productOne(productOne), .productTwo(productTwo),
        .productDoneOne(productDoneOne), .productDoneTwo(productDoneTwo),
        .sweep_done(sweep_done), .leak_seen(leak_seen), .err_seen(err_seen),
        .timeout_seen(timeout_seen), .leak_count(leak_count),
        .first_leak_idx(first_leak_idx)
    );

    // Mock multipliers: done pulses d cycles after start (d=0 means never).
    int           scen = 1;
    logic [W-1:0] a1, b1, a2, b2;
    int           c1, c2, d1, d2;
    logic         busy1 = 1'b0, busy2 = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else if (start) begin
            a1 <= multiplierOne;  b1 <= multiplicandOne;
            a2 <= multiplierTwo;  b2 <= multiplicandTwo;
            busy1 <= 1'b1;  busy2 <= 1'b1;
            c1 <= 1;  c2 <= 1;
            d1 <= 4;
            if (scen == 2 && multiplierTwo == 4'hF)
                d2 <= 5;
            else if (scen == 4 && multiplierTwo == 4'hE && multiplicandTwo == 4'hF)
                d2 <= 0;
            else
                d2 <= 4;
        end else begin
            if (busy1) begin c1 <= c1 + 1; if (c1 == d1) busy1 <= 1'b0; end
            if (busy2) begin c2 <= c2 + 1; if (c2 == d2) busy2 <= 1'b0; end
        end
    end

    assign productDoneOne = busy1 && (c1 == d1);
    assign productDoneTwo = busy2 && (c2 == d2);

    always_comb begin
        productOne = {4'b0, a1} * {4'b0, b1};
        if (scen == 3 && a1 == 4'h3 && b1 == 4'h7) productOne = productOne + 8'd1;
        productTwo = {4'b0, a2} * {4'b0, b2};
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    typedef struct {
        logic [W-1:0] m1, c1, m2, c2;
    } ops_t;

    typedef struct {
        logic       leak, err, tmo;
        logic [7:0] cnt;
        logic [7:0] first;
    } flags_t;

    ops_t   q_ops[$];
    flags_t q_flags[$];
    logic   prev_done = 1'b0;

    // Monitor: operands checked on every start, flags checked when sweep_done rises.
    always @(negedge clk) begin
        ops_t   e;
        flags_t f;
        if (start === 1'b1) begin
            if (q_ops.size() == 0) begin
                fail_msg("unexpected_start");
            end else begin
                e = q_ops.pop_front();
                check("multiplierOne", 32'(multiplierOne), 32'(e.m1));
                check("multiplicandOne", 32'(multiplicandOne), 32'(e.c1));
                check("multiplierTwo", 32'(multiplierTwo), 32'(e.m2));
                check("multiplicandTwo", 32'(multiplicandTwo), 32'(e.c2));
            end
        end
        if (sweep_done === 1'b1 && prev_done !== 1'b1) begin
            if (q_flags.size() == 0) begin
                fail_msg("unexpected_sweep_done");
            end else begin
                f = q_flags.pop_front();
                check("leak_seen", 32'(leak_seen), 32'(f.leak));
                check("err_seen", 32'(err_seen), 32'(f.err));
                check("timeout_seen", 32'(timeout_seen), 32'(f.tmo));
                check("leak_count", 32'(leak_count), 32'(f.cnt));
                check("first_leak_idx", 32'(first_leak_idx), 32'(f.first));
            end
        end
        prev_done <= sweep_done;
    end

    task automatic push_sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            ops_t o;
            logic [7:0] v;
            v = 8'(i);
            o.m1 = v[7:4];
            o.c1 = v[3:0];
            o.m2 = ~v[7:4];
            o.c2 = ~v[3:0];
            q_ops.push_back(o);
        end
    endtask

    task automatic run_sweep(input string name, input int last, input logic leak, input logic err,
                             input logic tmo, input logic [7:0] cnt, input logic [7:0] first);
        flags_t f;
        f.leak = leak; f.err = err; f.tmo = tmo; f.cnt = cnt; f.first = first;
        push_sweep(last);
        q_flags.push_back(f);
        run = 1'b1;
        for (int k = 0; k < 6000 && sweep_done !== 1'b1; k++) @(negedge clk);
        if (sweep_done !== 1'b1) begin
            fail_msg({name, "_sweep_timeout"});
            run = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            q_ops.delete();
            q_flags.delete();
        end else begin
            run = 1'b0;
            @(negedge clk);
            check({name, "_done_drop"}, 32'(sweep_done), 32'd0);
            check({name, "_leak_hold"}, 32'(leak_seen), 32'(leak));
            check({name, "_count_hold"}, 32'(leak_count), 32'(cnt));
            check({name, "_all_starts"}, 32'(q_ops.size()), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(start), 32'd0);
        check("rst_ops", 32'({multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo}), 32'd0);
        check("rst_flags", 32'({sweep_done, leak_seen, err_seen, timeout_seen}), 32'd0);
        check("rst_counts", 32'({leak_count, first_leak_idx}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        scen = 1;
        run_sweep("s1_clean", 255, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);

        scen = 2;
`ifdef MULT_DRV_STOP_ON_LEAK_EN
        run_sweep("s2_leak", 0, 1'b1, 1'b0, 1'b0, 8'd1, 8'h00);
`else
        run_sweep("s2_leak", 255, 1'b1, 1'b0, 1'b0, 8'd16, 8'h00);
`endif

        scen = 3;
        run_sweep("s3_err", 255, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00);

        scen = 4;
`ifdef MULT_DRV_STOP_ON_LEAK_EN
        run_sweep("s4_hang", 16, 1'b1, 1'b0, 1'b1, 8'd1, 8'h10);
`else
        run_sweep("s4_hang", 255, 1'b1, 1'b0, 1'b1, 8'd1, 8'h10);
`endif

        // Reset two cycles into WAIT of pair 0x20, then restart from 0.
        scen = 5;
        push_sweep(32);
        run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (start === 1'b1 && multiplierOne == 4'h2 && multiplicandOne == 4'h0) found = 1'b1;
        end
        if (!found) begin
            fail_msg("s5_reach_idx20");
        end else begin
            repeat (2) @(negedge clk);
            rst = 1'b1;
            run = 1'b0;
            @(negedge clk);
            check("s5_rst_start", 32'(start), 32'd0);
            check("s5_rst_ops", 32'({multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo}), 32'd0);
            check("s5_rst_flags", 32'({sweep_done, leak_seen, err_seen, timeout_seen}), 32'd0);
            check("s5_rst_counts", 32'({leak_count, first_leak_idx}), 32'd0);
            check("s5_starts_seen", 32'(q_ops.size()), 32'd0);
        end
        rst = 1'b0;
        q_ops.delete();
        repeat (4) @(negedge clk);
        run_sweep("s5_restart", 255, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
